// File: rtl/cpcs_tx_symbol_sched.sv
// TX symbol scheduler feeding the 8b/10b encoder: alignment burst, /I/ idles, periodic sync sets.
// Optional K-code legality check enabled by defining CPCS_TX_KCHK_EN.
module cpcs_tx_symbol_sched #(
  parameter int          SYNC_PERIOD = 1024,
  parameter int          ALIGN_LEN   = 4,
  parameter logic [7:0]  COMMA_CHAR  = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR   = 8'h50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_EN,
  input  logic [7:0] DIN,
  input  logic       KIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic [7:0] D,
  output logic       K,
  output logic       FORCE_DISP,
  output logic       DISP_SEL,
  output logic       ALIGNED,
  output logic       KERR
);

  typedef enum logic [1:0] {S_OFF, S_ALIGN, S_DATA, S_SYNC} state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;       // 1: a comma was just sent, its D16.2 must follow
  logic [7:0]  set_cnt_q, set_cnt_d;
  logic [15:0] sync_cnt_q, sync_cnt_d;
  logic        sync_due_q, sync_due_d;
  logic [7:0]  d_q, d_d;
  logic        k_q, k_d;
  logic        fd_q, fd_d;
  logic        ds_q, ds_d;
  logic        aligned_q, aligned_d;
  logic        kerr_q, kerr_d;

  logic        accept;
  logic [7:0]  user_d;
  logic        user_err;

`ifdef CPCS_TX_KCHK_EN
  function automatic logic k_legal(input logic [7:0] b);
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
      8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE: k_legal = 1'b1;
      default:                                   k_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    user_err = KIN && !k_legal(DIN);
    user_d   = user_err ? 8'hFE : DIN;
  end
`else
  always_comb begin
    user_err = 1'b0;
    user_d   = DIN;
  end
`endif

  assign DIN_READY = (state_q == S_DATA) && !sync_due_q && !phase_q && TX_EN;
  assign accept    = DIN_READY && DIN_VALID;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    set_cnt_d  = set_cnt_q;
    sync_cnt_d = sync_cnt_q;
    sync_due_d = sync_due_q;
    d_d        = 8'h00;
    k_d        = 1'b0;
    fd_d       = 1'b0;
    ds_d       = 1'b0;              // only RD- is ever forced
    kerr_d     = 1'b0;
    aligned_d  = (state_q == S_DATA) || (state_q == S_SYNC);
    case (state_q)
      S_OFF: begin
        phase_d    = 1'b0;
        sync_cnt_d = '0;
        sync_due_d = 1'b0;
        if (TX_EN) begin
          d_d       = COMMA_CHAR;
          k_d       = 1'b1;
          fd_d      = 1'b1;
          phase_d   = 1'b1;
          set_cnt_d = 8'd1;
          state_d   = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (phase_q) begin
          d_d     = IDLE_CHAR;
          phase_d = 1'b0;
          if (!TX_EN)                         state_d = S_OFF;
          else if (set_cnt_q == 8'(ALIGN_LEN)) state_d = S_DATA;
        end else if (!TX_EN) begin
          state_d = S_OFF;
        end else begin
          d_d       = COMMA_CHAR;
          k_d       = 1'b1;
          phase_d   = 1'b1;
          set_cnt_d = set_cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        if (phase_q) begin
          d_d     = IDLE_CHAR;
          phase_d = 1'b0;
          if (!TX_EN) state_d = S_OFF;
        end else if (!TX_EN) begin
          state_d = S_OFF;
        end else if (sync_due_q) begin
          d_d     = COMMA_CHAR;
          k_d     = 1'b1;
          phase_d = 1'b1;
          state_d = S_SYNC;
        end else if (accept) begin
          d_d        = user_d;
          k_d        = KIN;
          kerr_d     = user_err;
          sync_cnt_d = sync_cnt_q + 16'd1;
          if (sync_cnt_q == 16'(SYNC_PERIOD - 1)) sync_due_d = 1'b1;
        end else begin
          d_d        = COMMA_CHAR;
          k_d        = 1'b1;
          phase_d    = 1'b1;
          sync_cnt_d = '0;
        end
      end
      S_SYNC: begin
        d_d        = IDLE_CHAR;
        phase_d    = 1'b0;
        sync_cnt_d = '0;
        sync_due_d = 1'b0;
        state_d    = TX_EN ? S_DATA : S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_OFF;
      phase_q    <= 1'b0;
      set_cnt_q  <= '0;
      sync_cnt_q <= '0;
      sync_due_q <= 1'b0;
      d_q        <= 8'h00;
      k_q        <= 1'b0;
      fd_q       <= 1'b0;
      ds_q       <= 1'b0;
      aligned_q  <= 1'b0;
      kerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      set_cnt_q  <= set_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      sync_due_q <= sync_due_d;
      d_q        <= d_d;
      k_q        <= k_d;
      fd_q       <= fd_d;
      ds_q       <= ds_d;
      aligned_q  <= aligned_d;
      kerr_q     <= kerr_d;
    end
  end

  assign D          = d_q;
  assign K          = k_q;
  assign FORCE_DISP = fd_q;
  assign DISP_SEL   = ds_q;
  assign ALIGNED    = aligned_q;
  assign KERR       = kerr_q;

endmodule

// File: tb/tb_cpcs_tx_symbol_sched.sv
// Directed bench for cpcs_tx_symbol_sched (SYNC_PERIOD=16, ALIGN_LEN=4).
module tb_cpcs_tx_symbol_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TX_EN = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       KIN = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [7:0] D;
  logic       K, FORCE_DISP, DISP_SEL, ALIGNED, KERR;

  int  checks = 0;
  int  failures = 0;
  bit  auto_inc = 1'b0;

  cpcs_tx_symbol_sched #(.SYNC_PERIOD(16), .ALIGN_LEN(4)) dut (
    .CLK(CLK), .RST(RST), .TX_EN(TX_EN), .DIN(DIN), .KIN(KIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .D(D), .K(K),
    .FORCE_DISP(FORCE_DISP), .DISP_SEL(DISP_SEL), .ALIGNED(ALIGNED), .KERR(KERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    logic acc;
    #1;
    acc = DIN_READY && DIN_VALID;
    @(posedge CLK);
    #1;
    if (acc && auto_inc) DIN = DIN + 8'd1;
  endtask

  task automatic test_reset();
    RST = 1'b1; TX_EN = 1'b0;
    tick(); tick();
    checks++;
    if ({D, K, FORCE_DISP, DISP_SEL, ALIGNED, KERR, DIN_READY} !== 15'h0) begin
      failures++;
      $display("FAIL reset_vals got D=%h K=%b FD=%b DS=%b AL=%b KERR=%b RDY=%b exp all 0",
               D, K, FORCE_DISP, DISP_SEL, ALIGNED, KERR, DIN_READY);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (D !== 8'h00 || K !== 1'b0) begin
      failures++;
      $display("FAIL off_idle got D=%h K=%b exp D=00 K=0", D, K);
    end
  endtask

  // Starts from OFF; leaves the bench on the cycle showing the 8th align symbol.
  task automatic test_align();
    TX_EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ed;
      ed = (i % 2 == 0) ? 8'hBC : 8'h50;
      tick();
      checks++;
      if (D !== ed || K !== (i % 2 == 0) || FORCE_DISP !== (i == 0) || DISP_SEL !== 1'b0) begin
        failures++;
        $display("FAIL align[%0d] got D=%h K=%b FD=%b DS=%b exp D=%h K=%b FD=%b DS=0",
                 i, D, K, FORCE_DISP, DISP_SEL, ed, (i % 2 == 0), (i == 0));
      end
      checks++;
      if (ALIGNED !== 1'b0 || DIN_READY !== (i == 7)) begin
        failures++;
        $display("FAIL align_ctl[%0d] got AL=%b RDY=%b exp AL=0 RDY=%b", i, ALIGNED, DIN_READY, (i == 7));
      end
    end
  endtask

  task automatic test_sync();
    logic [7:0] ed [0:22];
    logic       ek [0:22];
    logic       er [0:22];
    for (int i = 0; i < 16; i++) begin ed[i] = 8'(i); ek[i] = 1'b0; er[i] = (i < 15); end
    ed[16] = 8'hBC; ek[16] = 1'b1; er[16] = 1'b0;
    ed[17] = 8'h50; ek[17] = 1'b0; er[17] = 1'b1;
    for (int i = 18; i < 23; i++) begin ed[i] = 8'(i - 2); ek[i] = 1'b0; er[i] = 1'b1; end
    DIN = 8'h00; KIN = 1'b0; DIN_VALID = 1'b1; auto_inc = 1'b1;
    for (int i = 0; i < 23; i++) begin
      tick();
      checks++;
      if (D !== ed[i] || K !== ek[i] || ALIGNED !== 1'b1) begin
        failures++;
        $display("FAIL sync_sym[%0d] got D=%h K=%b AL=%b exp D=%h K=%b AL=1", i, D, K, ALIGNED, ed[i], ek[i]);
      end
      checks++;
      if (DIN_READY !== er[i]) begin
        failures++;
        $display("FAIL sync_rdy[%0d] got %b exp %b", i, DIN_READY, er[i]);
      end
    end
  endtask

  task automatic test_idle();
    logic [7:0] ed [0:6] = '{8'hBC, 8'h50, 8'hBC, 8'h50, 8'hBC, 8'h50, 8'h15};
    logic       ek [0:6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       er [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    DIN_VALID = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 4) DIN_VALID = 1'b1;
      checks++;
      if (D !== ed[i] || K !== ek[i] || FORCE_DISP !== 1'b0) begin
        failures++;
        $display("FAIL idle_sym[%0d] got D=%h K=%b FD=%b exp D=%h K=%b FD=0", i, D, K, FORCE_DISP, ed[i], ek[i]);
      end
      checks++;
      if (DIN_READY !== er[i]) begin
        failures++;
        $display("FAIL idle_rdy[%0d] got %b exp %b", i, DIN_READY, er[i]);
      end
    end
  endtask

  task automatic test_txen_drop();
    DIN_VALID = 1'b0; auto_inc = 1'b0;
    tick();
    checks++;
    if (D !== 8'hBC || K !== 1'b1 || DIN_READY !== 1'b0) begin
      failures++;
      $display("FAIL drop_bc got D=%h K=%b RDY=%b exp D=bc K=1 RDY=0", D, K, DIN_READY);
    end
    TX_EN = 1'b0;
    tick();
    checks++;
    if (D !== 8'h50 || K !== 1'b0 || ALIGNED !== 1'b1) begin
      failures++;
      $display("FAIL drop_finish got D=%h K=%b AL=%b exp D=50 K=0 AL=1", D, K, ALIGNED);
    end
    tick();
    checks++;
    if (D !== 8'h00 || K !== 1'b0 || ALIGNED !== 1'b0 || DIN_READY !== 1'b0) begin
      failures++;
      $display("FAIL drop_off got D=%h K=%b AL=%b RDY=%b exp D=00 K=0 AL=0 RDY=0", D, K, ALIGNED, DIN_READY);
    end
    tick();
    checks++;
    if (D !== 8'h00 || ALIGNED !== 1'b0) begin
      failures++;
      $display("FAIL drop_hold got D=%h AL=%b exp D=00 AL=0", D, ALIGNED);
    end
    test_align();
    tick();
    checks++;
    if (D !== 8'hBC || K !== 1'b1 || FORCE_DISP !== 1'b0 || ALIGNED !== 1'b1) begin
      failures++;
      $display("FAIL realign_idle got D=%h K=%b FD=%b AL=%b exp D=bc K=1 FD=0 AL=1", D, K, FORCE_DISP, ALIGNED);
    end
    tick();
    checks++;
    if (D !== 8'h50 || DIN_READY !== 1'b1) begin
      failures++;
      $display("FAIL realign_50 got D=%h RDY=%b exp D=50 RDY=1", D, DIN_READY);
    end
  endtask

  task automatic test_reset_mid();
    DIN = 8'hA5; KIN = 1'b0; DIN_VALID = 1'b1;
    tick();
    checks++;
    if (D !== 8'hA5 || K !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_data got D=%h K=%b exp D=a5 K=0", D, K);
    end
    RST = 1'b1; DIN_VALID = 1'b0;
    tick();
    checks++;
    if ({D, K, FORCE_DISP, DISP_SEL, ALIGNED, KERR, DIN_READY} !== 15'h0) begin
      failures++;
      $display("FAIL rst_mid_vals got D=%h K=%b FD=%b DS=%b AL=%b KERR=%b RDY=%b exp all 0",
               D, K, FORCE_DISP, DISP_SEL, ALIGNED, KERR, DIN_READY);
    end
    RST = 1'b0;
    test_align();
  endtask

  task automatic test_kchk();
    logic [7:0] bad_d;
    logic       bad_e;
`ifdef CPCS_TX_KCHK_EN
    bad_d = 8'hFE; bad_e = 1'b1;
`else
    bad_d = 8'h3D; bad_e = 1'b0;
`endif
    DIN = 8'h3D; KIN = 1'b1; DIN_VALID = 1'b1;
    tick();
    checks++;
    if (D !== bad_d || K !== 1'b1 || KERR !== bad_e) begin
      failures++;
      $display("FAIL kchk_bad got D=%h K=%b KERR=%b exp D=%h K=1 KERR=%b", D, K, KERR, bad_d, bad_e);
    end
    DIN = 8'hBC;
    tick();
    checks++;
    if (D !== 8'hBC || K !== 1'b1 || KERR !== 1'b0) begin
      failures++;
      $display("FAIL kchk_good got D=%h K=%b KERR=%b exp D=bc K=1 KERR=0", D, K, KERR);
    end
    DIN_VALID = 1'b0; KIN = 1'b0;
    tick();
    checks++;
    if (D !== 8'hBC || K !== 1'b1 || KERR !== 1'b0 || FORCE_DISP !== 1'b0) begin
      failures++;
      $display("FAIL kchk_after got D=%h K=%b KERR=%b FD=%b exp D=bc K=1 KERR=0 FD=0", D, K, KERR, FORCE_DISP);
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_sync();
    test_idle();
    test_txen_drop();
    test_reset_mid();
    test_kchk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
